// File: rtl/bus_controller.sv
// Bus transaction sequencer: one-hot region select -> chip select with per-region wait states,
// RAM ready/timeout handshake, and single-cycle ready/error completion.
// Optional ROM write protection: define BUS_ROM_WRITE_PROTECT_EN.
module bus_controller #(
  parameter int unsigned ROM_WAIT    = 1,
  parameter int unsigned IO_WAIT     = 2,
  parameter int unsigned GFX_WAIT    = 0,
  parameter int unsigned RAM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        ROM_Select_H,
  input  logic        RAM_Select_H,
  input  logic        IO_Select_H,
  input  logic        Graphics_Select_H,
  input  logic [31:0] rom_rdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] io_rdata,
  input  logic [31:0] gfx_rdata,
  input  logic        ram_ready,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        io_cs,
  output logic        gfx_cs,
  output logic        mem_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;
  localparam logic [1:0] StErr    = 2'd3;

  localparam logic [1:0] RegRom = 2'd0;
  localparam logic [1:0] RegRam = 2'd1;
  localparam logic [1:0] RegIo  = 2'd2;
  localparam logic [1:0] RegGfx = 2'd3;

  localparam logic [7:0] RomWait = 8'(ROM_WAIT);
  localparam logic [7:0] IoWait  = 8'(IO_WAIT);
  localparam logic [7:0] GfxWait = 8'(GFX_WAIT);
  localparam logic [7:0] RamLast = 8'(RAM_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  region_q, region_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  sel;
  logic        one_hot;
  logic        wp_hit;
  logic        access;

  assign sel     = {Graphics_Select_H, IO_Select_H, RAM_Select_H, ROM_Select_H};
  assign one_hot = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);

`ifdef BUS_ROM_WRITE_PROTECT_EN
  assign wp_hit = cpu_we & ROM_Select_H;
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (one_hot && !wp_hit) begin
            we_d    = cpu_we;
            rdata_d = 32'h0;
            state_d = StAccess;
            if (ROM_Select_H) begin
              region_d = RegRom;
              cnt_d    = RomWait;
            end else if (RAM_Select_H) begin
              region_d = RegRam;
              cnt_d    = 8'd0;
            end else if (IO_Select_H) begin
              region_d = RegIo;
              cnt_d    = IoWait;
            end else begin
              region_d = RegGfx;
              cnt_d    = GfxWait;
            end
          end else begin
            state_d = StErr;
          end
        end
      end
      StAccess: begin
        if (region_q == RegRam) begin
          // RAM counts up towards the timeout; fixed regions count down to zero
          if (ram_ready) begin
            rdata_d = ram_rdata;
            state_d = StResp;
          end else if (cnt_q == RamLast) begin
            state_d = StErr;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (cnt_q == 8'd0) begin
          state_d = StResp;
          case (region_q)
            RegRom:  rdata_d = rom_rdata;
            RegIo:   rdata_d = io_rdata;
            default: rdata_d = gfx_rdata;
          endcase
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      region_q <= RegRom;
      we_q     <= 1'b0;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decode directly from reset registers so an async reset clears them at once
  assign access = (state_q == StAccess);

`ifdef BUS_ROM_WRITE_PROTECT_EN
  assign rom_cs = access && (region_q == RegRom) && !we_q;
`else
  assign rom_cs = access && (region_q == RegRom);
`endif
  assign ram_cs    = access && (region_q == RegRam);
  assign io_cs     = access && (region_q == RegIo);
  assign gfx_cs    = access && (region_q == RegGfx);
  assign mem_we    = access && we_q;
  assign cpu_ready = (state_q == StResp) || (state_q == StErr);
  assign cpu_err   = (state_q == StErr);
  assign cpu_rdata = ((state_q == StResp) && !we_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed scenarios plus randomized transactions
// checked against a latency/data model derived from the region rules.
module tb_bus_controller;

  localparam int unsigned RomW  = 1;
  localparam int unsigned IoW   = 2;
  localparam int unsigned GfxW  = 0;
  localparam int unsigned RamTo = 6;
  localparam int          Never = 1000;

`ifdef BUS_ROM_WRITE_PROTECT_EN
  localparam bit Wp = 1'b1;
`else
  localparam bit Wp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic        ROM_Select_H, RAM_Select_H, IO_Select_H, Graphics_Select_H;
  logic [31:0] rom_rdata, ram_rdata, io_rdata, gfx_rdata;
  logic        ram_ready;
  logic        rom_cs, ram_cs, io_cs, gfx_cs, mem_we;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_controller #(
    .ROM_WAIT   (RomW),
    .IO_WAIT    (IoW),
    .GFX_WAIT   (GfxW),
    .RAM_TIMEOUT(RamTo)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .ROM_Select_H     (ROM_Select_H),
    .RAM_Select_H     (RAM_Select_H),
    .IO_Select_H      (IO_Select_H),
    .Graphics_Select_H(Graphics_Select_H),
    .rom_rdata        (rom_rdata),
    .ram_rdata        (ram_rdata),
    .io_rdata         (io_rdata),
    .gfx_rdata        (gfx_rdata),
    .ram_ready        (ram_ready),
    .rom_cs           (rom_cs),
    .ram_cs           (ram_cs),
    .io_cs            (io_cs),
    .gfx_cs           (gfx_cs),
    .mem_we           (mem_we),
    .cpu_rdata        (cpu_rdata),
    .cpu_ready        (cpu_ready),
    .cpu_err          (cpu_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input logic [3:0] s);
    {Graphics_Select_H, IO_Select_H, RAM_Select_H, ROM_Select_H} = s;
  endtask

  // sel bit order: 0 ROM, 1 RAM, 2 IO, 3 GFX. d = ACCESS cycles before ram_ready pulses.
  task automatic run_txn(input logic [3:0] sel, input logic we, input int d,
                         input logic [31:0] data, input string name);
    logic [31:0] rd [4];
    logic [31:0] exp_data;
    bit          err;
    int          k;
    int          idx;
    for (int j = 0; j < 4; j++) rd[j] = $urandom;
    idx = 0;
    for (int j = 0; j < 4; j++) if (sel[j]) idx = j;
    rd[idx] = data;
    // Model: k = cycles after the acceptance edge until the completion cycle
    err = ($countones(sel) != 1) || (Wp && sel == 4'b0001 && we);
    if (err) k = 0;
    else if (sel == 4'b0010) begin
      if (d < int'(RamTo)) k = d + 1;
      else begin
        k   = RamTo;
        err = 1'b1;
      end
    end else if (sel == 4'b0001) k = RomW + 1;
    else if (sel == 4'b0100) k = IoW + 1;
    else k = GfxW + 1;
    exp_data = (err || we) ? 32'h0 : rd[idx];

    @(posedge clk); #1;
    rom_rdata = rd[0]; ram_rdata = rd[1]; io_rdata = rd[2]; gfx_rdata = rd[3];
    cpu_req = 1'b1; cpu_we = we; set_sel(sel); ram_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i <= k; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i < k) begin
        chk($sformatf("%s cs c%0d", name, i), 32'({gfx_cs, io_cs, ram_cs, rom_cs}), 32'(sel));
        chk($sformatf("%s we c%0d", name, i), 32'(mem_we), 32'(we));
        chk($sformatf("%s rdy c%0d", name, i), 32'({cpu_ready, cpu_err}), 32'h0);
        chk($sformatf("%s rdata c%0d", name, i), cpu_rdata, 32'h0);
        // Post-acceptance input changes must be ignored
        set_sel(4'($urandom));
        cpu_we = 1'($urandom);
      end else begin
        chk($sformatf("%s cs done", name), 32'({gfx_cs, io_cs, ram_cs, rom_cs, mem_we}), 32'h0);
        chk($sformatf("%s ready", name), 32'(cpu_ready), 32'h1);
        chk($sformatf("%s err", name), 32'(cpu_err), 32'(err));
        chk($sformatf("%s rdata", name), cpu_rdata, exp_data);
        cpu_req = 1'b0; cpu_we = 1'b0; set_sel(4'b0000);
      end
      ram_ready = (i == d);
    end
    @(posedge clk); #1;
    ram_ready = 1'b0;
    chk($sformatf("%s single pulse", name), 32'({cpu_ready, cpu_err}), 32'h0);
  endtask

  initial begin
    logic [3:0] s;
    int         r;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; set_sel(4'b0000); ram_ready = 1'b0;
    rom_rdata = 32'h0; ram_rdata = 32'h0; io_rdata = 32'h0; gfx_rdata = 32'h0;
    #3;
    chk("reset ctl", 32'({rom_cs, ram_cs, io_cs, gfx_cs, mem_we, cpu_ready, cpu_err}), 32'h0);
    chk("reset rdata", cpu_rdata, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle ctl", 32'({rom_cs, ram_cs, io_cs, gfx_cs, mem_we, cpu_ready, cpu_err}), 32'h0);
      chk("idle rdata", cpu_rdata, 32'h0);
    end

    run_txn(4'b0001, 1'b0, 0, 32'h0000_0013, "rom_rd");
    run_txn(4'b0010, 1'b0, 4, 32'hCAFE_F00D, "ram_rd");
    run_txn(4'b0010, 1'b1, 0, 32'h1234_5678, "ram_wr_fast");
    run_txn(4'b0010, 1'b0, Never, 32'hDEAD_BEEF, "ram_timeout");
    run_txn(4'b0010, 1'b0, RamTo - 1, 32'h0BAD_F00D, "ram_last");
    run_txn(4'b0000, 1'b0, 0, 32'h0, "unmapped");
    run_txn(4'b0110, 1'b0, 0, 32'h0, "multi_sel");
    run_txn(4'b0001, 1'b1, 0, 32'h5555_AAAA, "rom_wr");
    run_txn(4'b1000, 1'b0, 0, 32'hA5A5_0001, "gfx_rd");

    // IO write aborted by reset during its second ACCESS cycle
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; set_sel(4'b0100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort io_cs before", 32'({io_cs, mem_we}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("abort ctl", 32'({rom_cs, ram_cs, io_cs, gfx_cs, mem_we, cpu_ready, cpu_err}), 32'h0);
    cpu_req = 1'b0; cpu_we = 1'b0; set_sel(4'b0000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort no ready", 32'({cpu_ready, cpu_err, io_cs, mem_we}), 32'h0);
    end
    run_txn(4'b0100, 1'b0, 0, 32'h0000_10AD, "io_rd_after");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) s = 4'(1 << (r % 4));
      else if (r == 8) s = 4'b0000;
      else s = 4'b1001;
      run_txn(s, 1'($urandom), $urandom_range(0, RamTo + 1), $urandom,
              $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_controller.md
# bus_controller

Transaction sequencer between the CPU data port and the memory-mapped slaves, directly downstream of the address decoder. It consumes the decoder's four one-hot region selects (ROM, RAM, IO, Graphics) and produces chip-select strobes. Per-region wait states are inserted, with a ready/timeout handshake for RAM. Read data is steered back to the CPU and completed with a single-cycle ready or error pulse.

## Interface
- ROM_WAIT, 1: extra ACCESS cycles for ROM (0..255)
- IO_WAIT, 2: extra ACCESS cycles for IO (0..255)
- GFX_WAIT, 0: extra ACCESS cycles for Graphics (0..255)
- RAM_TIMEOUT, 255: ACCESS cycles allowed for ram_ready before error (1..255)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- ROM_Select_H, RAM_Select_H, IO_Select_H, Graphics_Select_H  in  1 each  decoder selects for the current address
- rom_rdata, ram_rdata, io_rdata, gfx_rdata  in  32 each  slave read data
- ram_ready  in  1  RAM completion, sampled only in ACCESS for a RAM transaction
- rom_cs, ram_cs, io_cs, gfx_cs  out  1 each  slave strobes
- mem_we  out  1  latched write enable to slaves
- cpu_rdata  out  32  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle error pulse, coincident with cpu_ready

## Operation
- States: IDLE, ACCESS, RESP, ERR. Reset: state IDLE; every output 0; cpu_rdata 0; counter 0.
- IDLE, cpu_req=1 with exactly one select high: latch region and cpu_we, load cnt (ROM_WAIT/IO_WAIT/GFX_WAIT; 0 for RAM) -> ACCESS.
- IDLE, cpu_req=1 with zero or more than one select high -> ERR.
- ACCESS:
  - Latched region's cs=1 and mem_we=latched we.
  - Fixed-wait region: cnt==0 -> RESP and capture region rdata, else cnt-1.
  - RAM: ram_ready=1 -> RESP and capture ram_rdata. Else, if cnt==RAM_TIMEOUT-1 -> ERR, else cnt+1.
- RESP: cpu_ready=1; cpu_rdata = captured data for reads, 0 for writes -> IDLE.
- ERR: cpu_ready=1, cpu_err=1, cpu_rdata=0, no cs -> IDLE.
- cpu_req dropping or selects changing after acceptance is ignored; the transaction completes on latched values.
- Counter is 8 bits; parameters outside the stated ranges are illegal.

## Timing
- Acceptance edge E0 (IDLE samples cpu_req=1).
- Fixed region: cs high for WAIT+1 cycles after E0; cpu_ready high in the cycle after edge E0+WAIT+1. Read latency: WAIT+2 cycles.
- RAM: cpu_ready in the cycle after the edge that samples ram_ready=1. If ram_ready stays 0, cpu_err fires after RAM_TIMEOUT ACCESS cycles.
- Decode error: cpu_ready/cpu_err high in the cycle after E0.
- The next request can be accepted no earlier than the edge after the RESP/ERR cycle. Minimum spacing: WAIT+3 cycles.
- rst_n low mid-transaction: all outputs go to 0 immediately (asynchronous), state returns to IDLE, and no ready is issued for the aborted access.

## Configuration
- BUS_ROM_WRITE_PROTECT_EN defined:
  - IDLE with cpu_req=1, cpu_we=1, ROM_Select_H=1 -> ERR.
  - rom_cs never asserts for writes.
- Undefined:
  - ROM writes run as normal ROM transactions (rom_cs, mem_we=1, ROM_WAIT cycles, cpu_ready, no error).

## Test plan
- Reset then idle: all outputs 0; after rst_n rises with cpu_req=0 for 10 cycles, outputs stay 0.
- ROM read, ROM_WAIT=1, rom_rdata=0x00000013: rom_cs high 2 cycles; cpu_ready pulse 3 cycles after E0 with cpu_rdata=0x00000013, cpu_err=0.
- RAM read, ram_ready raised 5 cycles after E0, ram_rdata=0xCAFEF00D: single cpu_ready the cycle after, data 0xCAFEF00D. With ram_ready tied 0 and RAM_TIMEOUT=4: cpu_err+cpu_ready in cycle 5 after E0.
- Unmapped access (all selects 0, e.g. address 0x00500000): cpu_ready=cpu_err=1 in the cycle after E0; no cs asserted.
- ROM write with macro defined -> cpu_err pulse, rom_cs never high. Without the macro -> rom_cs+mem_we for 2 cycles, cpu_ready without error.
- IO write (IO_WAIT=2), rst_n pulsed low during the 2nd ACCESS cycle: io_cs and mem_we drop immediately, no cpu_ready. A subsequent IO read completes normally.
